// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
//   Types and constants for the icache/dcache memory bus arbiter: the owner
//   enumeration, the tag-table entry layout and default sizing.
//   No ports (package).
// ----------------------------------------------------------------------------
package mem_arb_pkg;
  import sys_defs::*;

  localparam int NUM_MEM_TAGS         = 16;
  localparam int DEFAULT_STARVE_LIMIT = 4;

  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } mem_owner_t;

  typedef struct packed {
    logic       valid;
    mem_owner_t owner;
  } mem_tag_entry_t;

  // A requester is active whenever it drives anything other than BUS_NONE.
  function automatic logic is_request(input logic [1:0] cmd);
    return cmd != BUS_NONE;
  endfunction

endpackage : mem_arb_pkg

// File: rtl/sys_defs.sv
// ----------------------------------------------------------------------------
// sys_defs
//   System-wide definitions shared by the memory-side blocks: address width
//   and the memory bus command encodings.
//   No ports (package).
// ----------------------------------------------------------------------------
package sys_defs;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

endpackage : sys_defs

// File: rtl/mem_arb_tag_table.sv
// ----------------------------------------------------------------------------
// mem_arb_tag_table
//   Records which requester owns each outstanding memory tag.
//   Ports:
//     clock, reset        system clock, synchronous active-high reset
//     i_set_en            write entry i_set_tag <= {valid, i_set_owner}
//     i_set_tag/owner     tag accepted by memory and its owner
//     i_lookup_tag        completion tag to look up (combinational read)
//     i_clear_en          invalidate entry i_lookup_tag at the next edge
//     o_lookup_valid      entry for i_lookup_tag is outstanding
//     o_lookup_owner      owner recorded for i_lookup_tag
//   Tag 0 means "no tag": it never reads valid and is never written.
//   A set and a clear of the same tag in one cycle keeps the set.
// ----------------------------------------------------------------------------
module mem_arb_tag_table
  import mem_arb_pkg::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS,
  parameter int TAG_W    = $clog2(NUM_TAGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_set_en,
  input  logic [TAG_W-1:0] i_set_tag,
  input  mem_owner_t       i_set_owner,
  input  logic             i_clear_en,
  input  logic [TAG_W-1:0] i_lookup_tag,
  output logic             o_lookup_valid,
  output mem_owner_t       o_lookup_owner
);

  mem_tag_entry_t r_table [NUM_TAGS];

  assign o_lookup_valid = (i_lookup_tag != '0) && r_table[i_lookup_tag].valid;
  assign o_lookup_owner = r_table[i_lookup_tag].owner;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; here it also lets the later set override an earlier clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: only the valid bits are reset; owner fields are don't-care
      // until written, so they stay plain enable flops.
      for (int i = 0; i < NUM_TAGS; i++) begin
        r_table[i].valid <= 1'b0;
      end
    end else begin
      if (i_clear_en && (i_lookup_tag != '0)) begin
        r_table[i_lookup_tag].valid <= 1'b0;
      end
      // Re-issue of a tag completing this cycle: the new owner is kept.
      if (i_set_en && (i_set_tag != '0)) begin
        r_table[i_set_tag] <= '{valid: 1'b1, owner: i_set_owner};
      end
    end
  end

endmodule : mem_arb_tag_table

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares the single tagged memory port between the icache prefetcher and
//   the dcache. One command is granted per cycle (combinational issue path,
//   same-cycle response). The dcache has priority unless the icache has been
//   denied for STARVE_LIMIT consecutive request cycles. Returning data/tags
//   are steered to the requester that owns the tag.
//
//   Configuration macro MEM_ARB_PERF_EN: when defined, adds 32-bit wrapping
//   counters perf_icache_grants, perf_dcache_grants, perf_conflict_cycles.
//
//   Ports:
//     clock, reset            system clock, synchronous active-high reset
//     Icache2mem_*            icache prefetcher command/address
//     mem2Icache_response     accepted tag for an icache command, 0 = retry
//     mem2Icache_data/tag     icache-owned completion (tag 0 = none)
//     Dcache2mem_*            dcache command/address/store data
//     mem2Dcache_*            as icache side
//     proc2mem_*              granted command/address/data to memory
//     mem2proc_response       memory acceptance tag (0 = busy)
//     mem2proc_data/tag       memory completion (tag 0 = none)
// ----------------------------------------------------------------------------
module mem_bus_arbiter
  import sys_defs::*;
  import mem_arb_pkg::*;
#(
  parameter int NUM_TAGS     = NUM_MEM_TAGS,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [1:0]                  Icache2mem_command,
  input  logic [XLEN-1:0]             Icache2mem_addr,
  output logic [$clog2(NUM_TAGS)-1:0] mem2Icache_response,
  output logic [63:0]                 mem2Icache_data,
  output logic [$clog2(NUM_TAGS)-1:0] mem2Icache_tag,
  input  logic [1:0]                  Dcache2mem_command,
  input  logic [XLEN-1:0]             Dcache2mem_addr,
  input  logic [63:0]                 Dcache2mem_data,
  output logic [$clog2(NUM_TAGS)-1:0] mem2Dcache_response,
  output logic [63:0]                 mem2Dcache_data,
  output logic [$clog2(NUM_TAGS)-1:0] mem2Dcache_tag,
  output logic [1:0]                  proc2mem_command,
  output logic [XLEN-1:0]             proc2mem_addr,
  output logic [63:0]                 proc2mem_data,
  input  logic [$clog2(NUM_TAGS)-1:0] mem2proc_response,
  input  logic [63:0]                 mem2proc_data,
  input  logic [$clog2(NUM_TAGS)-1:0] mem2proc_tag
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]                 perf_icache_grants,
  output logic [31:0]                 perf_dcache_grants,
  output logic [31:0]                 perf_conflict_cycles
`endif
);

  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;

  logic       w_icache_req;
  logic       w_dcache_req;
  logic       w_force_icache;
  logic       w_grant_icache;
  logic       w_grant_dcache;
  logic       w_set_en;
  logic       w_clear_en;
  logic       w_lookup_valid;
  mem_owner_t w_lookup_owner;
  logic       w_route_icache;
  logic       w_route_dcache;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  assign w_icache_req   = is_request(Icache2mem_command);
  assign w_dcache_req   = is_request(Dcache2mem_command);
  assign w_force_icache = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Grants are suppressed in reset so nothing reaches memory or the table.
  assign w_grant_icache = !reset && w_icache_req && (!w_dcache_req || w_force_icache);
  assign w_grant_dcache = !reset && w_dcache_req && !w_grant_icache;

  // A zero response (memory busy) is forwarded but never recorded.
  assign w_set_en   = (w_grant_icache || w_grant_dcache) && (mem2proc_response != '0);
  assign w_clear_en = !reset && (mem2proc_tag != '0);

  assign w_route_icache = !reset && w_lookup_valid && (w_lookup_owner == OWNER_ICACHE);
  assign w_route_dcache = !reset && w_lookup_valid && (w_lookup_owner == OWNER_DCACHE);

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    proc2mem_command    = BUS_NONE;
    proc2mem_addr       = '0;
    proc2mem_data       = '0;
    mem2Icache_response = '0;
    mem2Dcache_response = '0;
    if (w_grant_icache) begin
      proc2mem_command    = Icache2mem_command;
      proc2mem_addr       = Icache2mem_addr;
      mem2Icache_response = mem2proc_response;
    end else if (w_grant_dcache) begin
      proc2mem_command    = Dcache2mem_command;
      proc2mem_addr       = Dcache2mem_addr;
      proc2mem_data       = Dcache2mem_data;
      mem2Dcache_response = mem2proc_response;
    end
  end

  // --------------------------------------------------------------------------
  // Completion steering: only the owning side sees a non-zero tag and data.
  // --------------------------------------------------------------------------
  always_comb begin
    mem2Icache_tag  = '0;
    mem2Icache_data = '0;
    mem2Dcache_tag  = '0;
    mem2Dcache_data = '0;
    if (w_route_icache) begin
      mem2Icache_tag  = mem2proc_tag;
      mem2Icache_data = mem2proc_data;
    end
    if (w_route_dcache) begin
      mem2Dcache_tag  = mem2proc_tag;
      mem2Dcache_data = mem2proc_data;
    end
  end

  mem_arb_tag_table #(
    .NUM_TAGS (NUM_TAGS),
    .TAG_W    (TAG_W)
  ) u_tag_table (
    .clock          (clock),
    .reset          (reset),
    .i_set_en       (w_set_en),
    .i_set_tag      (mem2proc_response),
    .i_set_owner    (w_grant_icache ? OWNER_ICACHE : OWNER_DCACHE),
    .i_clear_en     (w_clear_en),
    .i_lookup_tag   (mem2proc_tag),
    .o_lookup_valid (w_lookup_valid),
    .o_lookup_owner (w_lookup_owner)
  );

  // --------------------------------------------------------------------------
  // Starvation counter: counts consecutive denied icache request cycles.
  // A grant with a busy response still counts as a grant and clears it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!w_icache_req || w_grant_icache) begin
      r_starve_cnt <= '0;
    end else if (!w_force_icache) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_icache_grants;
  logic [31:0] r_perf_dcache_grants;
  logic [31:0] r_perf_conflict_cycles;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_icache_grants   <= '0;
      r_perf_dcache_grants   <= '0;
      r_perf_conflict_cycles <= '0;
    end else begin
      if (w_grant_icache) r_perf_icache_grants <= r_perf_icache_grants + 32'd1;
      if (w_grant_dcache) r_perf_dcache_grants <= r_perf_dcache_grants + 32'd1;
      if (w_icache_req && w_dcache_req) begin
        r_perf_conflict_cycles <= r_perf_conflict_cycles + 32'd1;
      end
    end
  end

  assign perf_icache_grants   = r_perf_icache_grants;
  assign perf_dcache_grants   = r_perf_dcache_grants;
  assign perf_conflict_cycles = r_perf_conflict_cycles;
`endif

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed stimulus for mem_bus_arbiter. A cycle-level reference model
//   (owner array + denied-streak count) predicts every output on each falling
//   edge; hand-computed literal expectations pin the key scenarios.
// ----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  import sys_defs::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  Icache2mem_command;
  logic [31:0] Icache2mem_addr;
  logic [3:0]  mem2Icache_response;
  logic [63:0] mem2Icache_data;
  logic [3:0]  mem2Icache_tag;
  logic [1:0]  Dcache2mem_command;
  logic [31:0] Dcache2mem_addr;
  logic [63:0] Dcache2mem_data;
  logic [3:0]  mem2Dcache_response;
  logic [63:0] mem2Dcache_data;
  logic [3:0]  mem2Dcache_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_icache_grants;
  logic [31:0] perf_dcache_grants;
  logic [31:0] perf_conflict_cycles;
`endif

  mem_bus_arbiter dut (
    .clock               (clock),
    .reset               (reset),
    .Icache2mem_command  (Icache2mem_command),
    .Icache2mem_addr     (Icache2mem_addr),
    .mem2Icache_response (mem2Icache_response),
    .mem2Icache_data     (mem2Icache_data),
    .mem2Icache_tag      (mem2Icache_tag),
    .Dcache2mem_command  (Dcache2mem_command),
    .Dcache2mem_addr     (Dcache2mem_addr),
    .Dcache2mem_data     (Dcache2mem_data),
    .mem2Dcache_response (mem2Dcache_response),
    .mem2Dcache_data     (mem2Dcache_data),
    .mem2Dcache_tag      (mem2Dcache_tag),
    .proc2mem_command    (proc2mem_command),
    .proc2mem_addr       (proc2mem_addr),
    .proc2mem_data       (proc2mem_data),
    .mem2proc_response   (mem2proc_response),
    .mem2proc_data       (mem2proc_data),
    .mem2proc_tag        (mem2proc_tag)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_icache_grants  (perf_icache_grants),
    .perf_dcache_grants  (perf_dcache_grants),
    .perf_conflict_cycles(perf_conflict_cycles)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. owner_tbl: 0 = free, 1 = icache, 2 = dcache.
  // denied = consecutive cycles the icache asked and lost.
  // --------------------------------------------------------------------------
  int owner_tbl [16];
  int denied;

  always @(negedge clock) begin
    logic        ireq, dreq, ig, dg;
    int          own;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [63:0] e_pdata;
    if (reset) begin
      check("mdl_rst_cmd",   64'(proc2mem_command),    64'd0);
      check("mdl_rst_addr",  64'(proc2mem_addr),       64'd0);
      check("mdl_rst_pdata", proc2mem_data,            64'd0);
      check("mdl_rst_iresp", 64'(mem2Icache_response), 64'd0);
      check("mdl_rst_dresp", 64'(mem2Dcache_response), 64'd0);
      check("mdl_rst_itag",  64'(mem2Icache_tag),      64'd0);
      check("mdl_rst_dtag",  64'(mem2Dcache_tag),      64'd0);
      check("mdl_rst_idata", mem2Icache_data,          64'd0);
      check("mdl_rst_ddata", mem2Dcache_data,          64'd0);
      denied = 0;
      for (int i = 0; i < 16; i++) owner_tbl[i] = 0;
    end else begin
      ireq = (Icache2mem_command != BUS_NONE);
      dreq = (Dcache2mem_command != BUS_NONE);
      ig   = ireq && (!dreq || denied >= 4);
      dg   = dreq && !ig;
      e_cmd   = ig ? Icache2mem_command : (dg ? Dcache2mem_command : 2'(BUS_NONE));
      e_addr  = ig ? Icache2mem_addr : (dg ? Dcache2mem_addr : 32'd0);
      e_pdata = dg ? Dcache2mem_data : 64'd0;
      own     = (mem2proc_tag != 4'd0) ? owner_tbl[mem2proc_tag] : 0;
      check("mdl_cmd",   64'(proc2mem_command),    64'(e_cmd));
      check("mdl_addr",  64'(proc2mem_addr),       64'(e_addr));
      check("mdl_pdata", proc2mem_data,            e_pdata);
      check("mdl_iresp", 64'(mem2Icache_response), ig ? 64'(mem2proc_response) : 64'd0);
      check("mdl_dresp", 64'(mem2Dcache_response), dg ? 64'(mem2proc_response) : 64'd0);
      check("mdl_itag",  64'(mem2Icache_tag),      own == 1 ? 64'(mem2proc_tag) : 64'd0);
      check("mdl_idata", mem2Icache_data,          own == 1 ? mem2proc_data : 64'd0);
      check("mdl_dtag",  64'(mem2Dcache_tag),      own == 2 ? 64'(mem2proc_tag) : 64'd0);
      check("mdl_ddata", mem2Dcache_data,          own == 2 ? mem2proc_data : 64'd0);
      // State after the coming edge: completion frees, then a new acceptance claims.
      if (mem2proc_tag != 4'd0) owner_tbl[mem2proc_tag] = 0;
      if ((ig || dg) && mem2proc_response != 4'd0) owner_tbl[mem2proc_response] = ig ? 1 : 2;
      if (!ireq || ig) denied = 0;
      else if (denied < 4) denied = denied + 1;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: drive just after the rising edge, return at the
  // falling edge so literal checks see settled outputs.
  // --------------------------------------------------------------------------
  task automatic drive(input logic rst,
                       input logic [1:0] ic, input logic [31:0] ia,
                       input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                       input logic [3:0] mr, input logic [3:0] mt, input logic [63:0] md);
    @(posedge clock);
    #1;
    reset              = rst;
    Icache2mem_command = ic;
    Icache2mem_addr    = ia;
    Dcache2mem_command = dc;
    Dcache2mem_addr    = da;
    Dcache2mem_data    = dd;
    mem2proc_response  = mr;
    mem2proc_tag       = mt;
    mem2proc_data      = md;
    @(negedge clock);
  endtask

  task automatic cyc(input logic [1:0] ic, input logic [31:0] ia,
                     input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                     input logic [3:0] mr, input logic [3:0] mt, input logic [63:0] md);
    drive(1'b0, ic, ia, dc, da, dd, mr, mt, md);
  endtask

  task automatic idle();
    cyc(BUS_NONE, 32'd0, BUS_NONE, 32'd0, 64'd0, 4'd0, 4'd0, 64'd0);
  endtask

  task automatic ret(input logic [3:0] mt, input logic [63:0] md);
    cyc(BUS_NONE, 32'd0, BUS_NONE, 32'd0, 64'd0, 4'd0, mt, md);
  endtask

  initial begin
    reset = 1'b1;
    Icache2mem_command = BUS_NONE; Icache2mem_addr = '0;
    Dcache2mem_command = BUS_NONE; Dcache2mem_addr = '0; Dcache2mem_data = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;

    drive(1'b1, BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
    drive(1'b1, BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
    check("rst_cmd",  64'(proc2mem_command), 64'd0);
    check("rst_itag", 64'(mem2Icache_tag),   64'd0);

    // 1: lone dcache load, accepted with tag 3, completes later.
    cyc(BUS_NONE, 0, BUS_LOAD, 32'h100, 0, 4'd3, 0, 0);
    check("t1_cmd",   64'(proc2mem_command),    64'(BUS_LOAD));
    check("t1_addr",  64'(proc2mem_addr),       64'h100);
    check("t1_dresp", 64'(mem2Dcache_response), 64'd3);
    check("t1_iresp", 64'(mem2Icache_response), 64'd0);
    idle();
    ret(4'd3, 64'hDEAD_BEEF_0000_0003);
    check("t1_dtag",  64'(mem2Dcache_tag),  64'd3);
    check("t1_ddata", mem2Dcache_data,      64'hDEAD_BEEF_0000_0003);
    check("t1_itag",  64'(mem2Icache_tag),  64'd0);
    check("t1_idata", mem2Icache_data,      64'd0);

    // 2: both load every cycle; icache forced on the fifth cycle only.
    for (int k = 0; k < 6; k++) begin
      cyc(BUS_LOAD, 32'h200 + 32'(8 * k), BUS_LOAD, 32'h300 + 32'(8 * k), 0,
          4'(10 + k), 0, 0);
      check("t2_iresp", 64'(mem2Icache_response), (k == 4) ? 64'(10 + k) : 64'd0);
      check("t2_dresp", 64'(mem2Dcache_response), (k == 4) ? 64'd0 : 64'(10 + k));
      check("t2_addr",  64'(proc2mem_addr),
            (k == 4) ? 64'(32'h200 + 8 * k) : 64'(32'h300 + 8 * k));
    end
    idle();

    // 3: icache load tag 5, dcache store tag 6; returns 6 then 5.
    cyc(BUS_LOAD, 32'h400, BUS_NONE, 0, 0, 4'd5, 0, 0);
    check("t3_iresp", 64'(mem2Icache_response), 64'd5);
    cyc(BUS_NONE, 0, BUS_STORE, 32'h480, 64'hCAFE_F00D_1234_5678, 4'd6, 0, 0);
    check("t3_cmd",   64'(proc2mem_command),    64'(BUS_STORE));
    check("t3_pdata", proc2mem_data,            64'hCAFE_F00D_1234_5678);
    check("t3_dresp", 64'(mem2Dcache_response), 64'd6);
    ret(4'd6, 64'hAAAA_0006);
    check("t3_dtag6", 64'(mem2Dcache_tag), 64'd6);
    check("t3_itag6", 64'(mem2Icache_tag), 64'd0);
    ret(4'd5, 64'hBBBB_0005);
    check("t3_itag5",  64'(mem2Icache_tag), 64'd5);
    check("t3_idata5", mem2Icache_data,     64'hBBBB_0005);
    check("t3_dtag5",  64'(mem2Dcache_tag), 64'd0);
    ret(4'd6, 64'hAAAA_0066);
    check("t3_empty6", 64'({mem2Icache_tag, mem2Dcache_tag}), 64'd0);
    ret(4'd5, 64'hBBBB_0055);
    check("t3_empty5", 64'({mem2Icache_tag, mem2Dcache_tag}), 64'd0);

    // Memory busy: response 0 passed through, nothing recorded.
    cyc(BUS_NONE, 0, BUS_LOAD, 32'h500, 0, 4'd0, 0, 0);
    check("busy_cmd",   64'(proc2mem_command),    64'(BUS_LOAD));
    check("busy_dresp", 64'(mem2Dcache_response), 64'd0);

    // 4: stray completion.
    ret(4'd9, 64'h9999);
    check("t4_tags",  64'({mem2Icache_tag, mem2Dcache_tag}), 64'd0);
    check("t4_ddata", mem2Dcache_data, 64'd0);

    // 5: tag 7 completes for icache while reissued to dcache.
    cyc(BUS_LOAD, 32'h600, BUS_NONE, 0, 0, 4'd7, 0, 0);
    cyc(BUS_NONE, 0, BUS_LOAD, 32'h680, 0, 4'd7, 4'd7, 64'hC0C0_0007);
    check("t5_itag",  64'(mem2Icache_tag),      64'd7);
    check("t5_idata", mem2Icache_data,          64'hC0C0_0007);
    check("t5_dtag",  64'(mem2Dcache_tag),      64'd0);
    check("t5_dresp", 64'(mem2Dcache_response), 64'd7);
    ret(4'd7, 64'hD0D0_0007);
    check("t5_dtag2", 64'(mem2Dcache_tag), 64'd7);
    check("t5_itag2", 64'(mem2Icache_tag), 64'd0);

    // 6: reset with tags 2 and 4 outstanding.
    cyc(BUS_NONE, 0, BUS_LOAD, 32'h700, 0, 4'd2, 0, 0);
    cyc(BUS_LOAD, 32'h740, BUS_NONE, 0, 0, 4'd4, 0, 0);
    drive(1'b1, BUS_LOAD, 32'h780, BUS_LOAD, 32'h7C0, 64'h55, 4'd8, 4'd4, 64'hEEEE);
    check("t6_rcmd",  64'(proc2mem_command), 64'd0);
    check("t6_rtags", 64'({mem2Icache_tag, mem2Dcache_tag}), 64'd0);
    check("t6_rresp", 64'({mem2Icache_response, mem2Dcache_response}), 64'd0);
    drive(1'b1, BUS_LOAD, 32'h780, BUS_LOAD, 32'h7C0, 64'h55, 4'd8, 4'd2, 64'hEEEE);
    ret(4'd2, 64'hF2F2);
    check("t6_tag2", 64'({mem2Icache_tag, mem2Dcache_tag}), 64'd0);
    ret(4'd4, 64'hF4F4);
    check("t6_tag4", 64'({mem2Icache_tag, mem2Dcache_tag}), 64'd0);
    ret(4'd8, 64'hF8F8);
    check("t6_tag8", 64'({mem2Icache_tag, mem2Dcache_tag}), 64'd0);
    cyc(BUS_LOAD, 32'h800, BUS_LOAD, 32'h840, 0, 4'd1, 0, 0);
    check("t6_post_dresp", 64'(mem2Dcache_response), 64'd1);
    ret(4'd1, 64'h1111);
    check("t6_post_dtag", 64'(mem2Dcache_tag), 64'd1);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_bus_arbiter
